// File: rtl/lsu_pkg.sv
// Shared definitions for the multicycle load/store unit: opcodes, FSM states,
// fault reasons and the byte-lane load formatting helper.
package lsu_pkg;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LB  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b010;
    localparam logic [2:0] OP_SW  = 3'b100;
    localparam logic [2:0] OP_SB  = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } lsu_state_e;

    localparam logic [1:0] FR_NONE     = 2'd0;
    localparam logic [1:0] FR_RESERVED = 2'd1;
    localparam logic [1:0] FR_MISALIGN = 2'd2;
    localparam logic [1:0] FR_RANGE    = 2'd3;

    // True for the five implemented opcodes.
    function automatic logic op_legal(input logic [2:0] op);
        return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU) ||
               (op == OP_SW) || (op == OP_SB);
    endfunction

    // Pick a little-endian byte lane out of a word and sign- or zero-extend it.
    function automatic logic [31:0] lane_extend(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic        sext);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return sext ? {{24{b[7]}}, b} : {24'h0, b};
    endfunction

endpackage

// File: rtl/lsu_dmem.sv
// Single-port DEPTH x 32 data RAM with per-byte write enables and a registered
// read port. Contents are never reset; the read returns the pre-write word.
module lsu_dmem #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Byte-lane write and registered read of the same (old) word
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int i = 0; i < 4; i++) begin
                if (we_i && be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lsu_multicycle.sv
// Multicycle load/store unit: captures one request per handshake, forms and
// checks the effective address, waits WAIT_STATES cycles, accesses the data
// RAM and returns a one-cycle completion / register write-back pulse.
module lsu_multicycle
    import lsu_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 1,
    parameter int REG_AW      = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [31:0]       req_base,
    input  logic [15:0]       req_offset,
    input  logic [REG_AW-1:0] req_rt,
    input  logic [31:0]       req_wdata,
    output logic              done,
    output logic              fault,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_reg,
    output logic [31:0]       wb_data
);

    localparam int          AW    = $clog2(DEPTH);
    localparam logic [31:0] LIMIT = 32'(DEPTH * 4);
    localparam logic [2:0]  WLAST = 3'(WAIT_STATES - 1);

    lsu_state_e        state_q;
    logic [2:0]        cnt_q;
    logic [1:0]        fr_q;
    logic              ready_q, done_q, fault_q, wb_valid_q;
    logic [REG_AW-1:0] wb_reg_q;
    logic [31:0]       wb_data_q;

    logic [2:0]        op_q;
    logic [31:0]       base_q, wdata_q;
    logic [15:0]       offset_q;
    logic [REG_AW-1:0] rt_q;
    logic [AW+1:0]     ea_q;

    logic [31:0]       ea_d;
    logic [1:0]        fr_d;
    logic [3:0]        be;
    logic [31:0]       mem_wdata, mem_rdata, load_data;
    logic              mem_en, mem_we;

    // Address unit: 32-bit wrapping add with sign-extended offset, then fault checks
    always_comb begin
        ea_d = base_q + {{16{offset_q[15]}}, offset_q};
        fr_d = FR_NONE;
        if (!op_legal(op_q)) begin
            fr_d = FR_RESERVED;
        end else if ((op_q == OP_LW || op_q == OP_SW) && ea_d[1:0] != 2'b00) begin
            fr_d = FR_MISALIGN;
        end else if (ea_d >= LIMIT) begin
            fr_d = FR_RANGE;
        end
    end

    // Store lane steering and load formatting; only legal ops ever reach ACCESS
    always_comb begin
        be        = (op_q == OP_SW) ? 4'hF : (4'b0001 << ea_q[1:0]);
        mem_wdata = (op_q == OP_SW) ? wdata_q : {4{wdata_q[7:0]}};
        case (op_q)
            OP_LB:   load_data = lane_extend(mem_rdata, ea_q[1:0], 1'b1);
            OP_LBU:  load_data = lane_extend(mem_rdata, ea_q[1:0], 1'b0);
            default: load_data = mem_rdata;
        endcase
    end

    assign mem_en = (state_q == ST_ACCESS);
    assign mem_we = mem_en && op_q[2];

    lsu_dmem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_dmem (
        .clk     (clk),
        .en_i    (mem_en),
        .we_i    (mem_we),
        .be_i    (be),
        .addr_i  (ea_q[AW+1:2]),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    // Request capture in IDLE and effective-address capture in ADDR
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && req_valid) begin
            op_q     <= req_op;
            base_q   <= req_base;
            offset_q <= req_offset;
            rt_q     <= req_rt;
            wdata_q  <= req_wdata;
        end
        if (state_q == ST_ADDR) begin
            ea_q <= ea_d[AW+1:0];
        end
    end

    // Control FSM with registered handshake and write-back outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            fr_q       <= FR_NONE;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_reg_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        state_q <= ST_ADDR;
                        ready_q <= 1'b0;
                    end
                end
                ST_ADDR: begin
                    fr_q <= fr_d;
                    if (fr_d != FR_NONE) begin
                        state_q <= ST_RESP;
                    end else if (WAIT_STATES == 0) begin
                        state_q <= ST_ACCESS;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == WLAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_ACCESS;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                ST_ACCESS: begin
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    done_q   <= 1'b1;
                    fault_q  <= (fr_q != FR_NONE);
                    wb_reg_q <= rt_q;
                    if (fr_q == FR_NONE && !op_q[2]) begin
                        wb_data_q  <= load_data;
                        wb_valid_q <= (rt_q != '0);
                    end
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign wb_valid  = wb_valid_q;
    assign wb_reg    = wb_reg_q;
    assign wb_data   = wb_data_q;

endmodule
